multicycle_control32: RTL and testbench

Multi-cycle main control FSM for the 32-bit MIPS-subset processor. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and write-back steps. It decodes the same opcode set as the single-cycle `control32` and adds ADDI, so the multi-cycle core executes the same programs. It sits between the instruction register (opcode field) and the datapath muxes and enables, and stalls on a memory-ready handshake.

---
 rtl/multicycle_control32_pkg.sv | 74 +++++++
 rtl/mc_ctrl_decode.sv | 80 ++++++++
 rtl/multicycle_control32.sv | 96 +++++++++
 tb/tb_multicycle_control32.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control32_pkg.sv
// rtl/multicycle_control32_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
// Purpose: opcode constants, state encodings, ALU/PC mux codes and the control
//          word carried from the decoder to the top-level ports.
// Ports:   none (package).

package multicycle_control32_pkg;

  // Supported opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // State encodings; 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_I_EXEC   = 4'd11,
    ST_I_WB     = 4'd12
  } state_t;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_J)  ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state/opcode to control-word decoder
// Purpose: Moore decode of the datapath control word from the current state.
//          Only IRWrite/PCWrite in FETCH look at mem_ready, and only DECODE
//          and BRANCH look at the opcode.
// Ports:   state     - current FSM state
//          opcode    - instruction[31:26] from the IR
//          mem_ready - memory handshake (used in FETCH only)
//          ctrl      - decoded control word

module mc_ctrl_decode
  import multicycle_control32_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // PC+4 and IR load only on the completing cycle of the fetch
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.illegal_op = ~is_legal_op(opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_op           = ALUOP_SUB;
        ctrl.pc_source        = PCSRC_ALUOUT;
        ctrl.pc_write_cond    = (opcode == OP_BEQ);
        ctrl.pc_write_cond_ne = (opcode == OP_BNE);
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control32.sv
// rtl/multicycle_control32.sv - multi-cycle main control FSM for the 32-bit MIPS subset
// Purpose: holds the state register and next-state logic; the control word is
//          decoded combinationally from the state by mc_ctrl_decode, so an
//          asynchronous reset drops memory requests immediately.
// Ports:   clk, reset (async, active-high), opcode (IR[31:26]), mem_ready,
//          PC/memory/register/ALU control outputs, illegal_op pulse, state.

module multicycle_control32
  import multicycle_control32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_IDLE:     w_next = ST_FETCH;
      ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_next = ST_R_EXEC;
          OP_LW, OP_SW:  w_next = ST_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = ST_BRANCH;
          OP_J:          w_next = ST_JUMP;
          OP_ADDI:       w_next = ST_I_EXEC;
          default:       w_next = ST_FETCH;  // illegal: retire as NOP
        endcase
      end
      // Only LW/SW reach MEM_ADDR, so anything but SW is a load
      ST_MEM_ADDR: w_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   w_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   w_next = ST_FETCH;
      ST_MEM_WR:   w_next = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:   w_next = ST_R_WB;
      ST_R_WB:     w_next = ST_FETCH;
      ST_BRANCH:   w_next = ST_FETCH;
      ST_JUMP:     w_next = ST_FETCH;
      ST_I_EXEC:   w_next = ST_I_WB;
      ST_I_WB:     w_next = ST_FETCH;
      default:     w_next = ST_FETCH;  // unused encodings recover
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (r_state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (w_ctrl)
  );

  assign PCWrite       = w_ctrl.pc_write;
  assign PCWriteCond   = w_ctrl.pc_write_cond;
  assign PCWriteCondNE = w_ctrl.pc_write_cond_ne;
  assign IorD          = w_ctrl.i_or_d;
  assign MemRead       = w_ctrl.mem_read;
  assign MemWrite      = w_ctrl.mem_write;
  assign IRWrite       = w_ctrl.ir_write;
  assign MemtoReg      = w_ctrl.mem_to_reg;
  assign RegDst        = w_ctrl.reg_dst;
  assign RegWrite      = w_ctrl.reg_write;
  assign ALUSrcA       = w_ctrl.alu_src_a;
  assign ALUSrcB       = w_ctrl.alu_src_b;
  assign ALUOp         = w_ctrl.alu_op;
  assign PCSource      = w_ctrl.pc_source;
  assign illegal_op    = w_ctrl.illegal_op;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control32.sv
// tb/tb_multicycle_control32.sv - self-checking bench for multicycle_control32

module tb_multicycle_control32;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                 S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_R_EXEC = 7,
                 S_R_WB = 8, S_BRANCH = 9, S_JUMP = 10, S_I_EXEC = 11,
                 S_I_WB = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_control32 dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  wire [17:0] obs_ctrl = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead,
                          MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                          ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};

  function automatic bit op_known(input logic [5:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: expected control word for a cycle, straight from the state table
  function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input logic [5:0] op);
    logic pcw = 0, pcc = 0, pcne = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, srca = 0, ill = 0;
    logic [1:0] srcb = 0, aluop = 0, pcsrc = 0;
    case (st)
      S_FETCH:    begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   begin srcb = 2'b11; ill = !op_known(op); end
      S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mw = 1; iord = 1; end
      S_R_EXEC:   begin srca = 1; aluop = 2'b10; end
      S_R_WB:     begin rw = 1; rdst = 1; end
      S_BRANCH:   begin srca = 1; aluop = 2'b01; pcsrc = 2'b01;
                        pcc = (op == 6'h04); pcne = (op == 6'h05); end
      S_JUMP:     begin pcw = 1; pcsrc = 2'b10; end
      S_I_EXEC:   begin srca = 1; srcb = 2'b10; end
      S_I_WB:     begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcc, pcne, iord, mr, mw, irw, m2r, rdst, rw, srca,
            srcb, aluop, pcsrc, ill};
  endfunction

  // Expected per-cycle schedule of the current instruction
  int q_st[$];
  bit q_rdy[$];

  task automatic push_wait(input int st, input int stalls);
    repeat (stalls) begin q_st.push_back(st); q_rdy.push_back(1'b0); end
    q_st.push_back(st); q_rdy.push_back(1'b1);
  endtask

  // mem_ready is randomised where the FSM must ignore it
  task automatic push_one(input int st);
    q_st.push_back(st); q_rdy.push_back(1'($urandom_range(0, 1)));
  endtask

  int cyc = 0;

  task automatic check_cycle(input int st, input bit rdy, input logic [5:0] op);
    check($sformatf("state c%0d", cyc), 32'(state), 32'(st));
    check($sformatf("ctrl c%0d st%0d", cyc, st), 32'(obs_ctrl), 32'(exp_ctrl(st, rdy, op)));
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input bit abort_wr);
    q_st.delete(); q_rdy.delete();
    push_wait(S_FETCH, fs);
    push_one(S_DECODE);
    case (op)
      6'h00: begin push_one(S_R_EXEC); push_one(S_R_WB); end
      6'h23: begin push_one(S_MEM_ADDR); push_wait(S_MEM_RD, ms); push_one(S_MEM_WB); end
      6'h2B: begin push_one(S_MEM_ADDR); push_wait(S_MEM_WR, ms); end
      6'h04, 6'h05: push_one(S_BRANCH);
      6'h02: push_one(S_JUMP);
      6'h08: begin push_one(S_I_EXEC); push_one(S_I_WB); end
      default: ;
    endcase
    for (int i = 0; i < q_st.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) opcode = op;
      mem_ready = q_rdy[i];
      @(negedge clk);
      cyc++;
      check_cycle(q_st[i], q_rdy[i], op);
      if (abort_wr && q_st[i] == S_MEM_WR && !q_rdy[i]) begin
        #1 reset = 1'b1;
        #1;
        check("async rst state", 32'(state), 32'(S_IDLE));
        check("async rst MemWrite", 32'(MemWrite), 32'd0);
        check("async rst ctrl", 32'(obs_ctrl), 32'd0);
        return;
      end
    end
  endtask

  task automatic hold_and_release(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset state", 32'(state), 32'(S_IDLE));
      check("reset ctrl", 32'(obs_ctrl), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post-reset idle", 32'(state), 32'(S_IDLE));
    check("post-reset ctrl", 32'(obs_ctrl), 32'd0);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    int r = $urandom_range(0, 7);
    if (r < 7) return legal_ops[r];
    do op = 6'($urandom); while (op_known(op));
    return op;
  endfunction

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'h00;
    hold_and_release(3);

    // Directed sequence from the plan
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h23, 0, 2, 0);
    run_instr(6'h2B, 0, 0, 0);
    run_instr(6'h04, 0, 0, 0);
    run_instr(6'h05, 0, 0, 0);
    run_instr(6'h02, 0, 0, 0);
    run_instr(6'h3F, 0, 0, 0);
    run_instr(6'h08, 1, 0, 0);

    // Random instruction mix with random stalls
    repeat (120) run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3), 0);

    // Asynchronous reset in the middle of a stalled store
    run_instr(6'h2B, 0, 3, 1);
    hold_and_release(1);
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h23, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
